shift_sequencer: RTL and testbench

- Multi-cycle controller that sequences the ALU's 8-bit shift-register datapath: it loads an operand, then applies one single-bit shift or rotate per enabled cycle until the requested amount is reached.
- It presents the result and the last bit shifted out, with a start/busy/done handshake toward the ALU top-level control.
- It replaces a wide barrel shifter with a small FSM plus counter.

---
 rtl/shift_sequencer_if.sv | 28 ++
 rtl/shift_sequencer.sv | 115 +++++++++++
 tb/tb_shift_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Handshake and data bundle between the ALU top-level control and the
// shift sequencer.
//   master : control side; drives en/start/din/amount/op, observes results.
//   slave  : sequencer side; observes requests, drives busy/done/dout/carry.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             en;
  logic             start;
  logic [WIDTH-1:0] din;
  logic [AMT_W-1:0] amount;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             carry;

  modport master (
    output en, start, din, amount, op,
    input  busy, done, dout, carry
  );

  modport slave (
    input  en, start, din, amount, op,
    output busy, done, dout, carry
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: loads an operand and applies one
// single-bit step per enabled cycle until the requested amount is reached.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : shift_sequencer_if.slave
//          en     - cycle enable, everything holds when low
//          start  - request, accepted only in IDLE
//          din    - operand, captured with start
//          amount - number of single-bit steps (0..WIDTH-1)
//          op     - 00 LSL, 01 LSR, 10 ASR, 11 ROL
//          busy   - high in SHIFT and DONE
//          done   - one-cycle completion pulse (held while stalled)
//          dout   - last completed result
//          carry  - last bit shifted/rotated out of the completed op
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic               clk,
  input logic               rst,
  shift_sequencer_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'b001;
  localparam logic [2:0] SHIFT = 3'b010;
  localparam logic [2:0] DONE  = 3'b100;

  logic [2:0]       state;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             shout;
  logic [WIDTH-1:0] dout_q;
  logic             carry_q;

  logic [WIDTH:0]   step_p0;
  logic [WIDTH-1:0] step_val;
  logic             step_out;

  // One single-bit step. Result is {out_bit, new_register}.
  function automatic logic [WIDTH:0] shift_step(
    input logic [WIDTH-1:0] r,
    input logic [1:0]       o
  );
    logic signed [WIDTH-1:0] sr;
    logic        [WIDTH:0]   res;
    sr  = r;
    res = '0;
    case (o)
      2'b00:   res = {r[WIDTH-1], r[WIDTH-2:0], 1'b0};
      2'b01:   res = {r[0], 1'b0, r[WIDTH-1:1]};
      2'b10:   res = {r[0], sr >>> 1};
      default: res = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
    endcase
    return res;
  endfunction

  // Combinational step from the working register
  assign step_p0  = shift_step(work, op_q);
  assign step_val = step_p0[WIDTH-1:0];
  assign step_out = step_p0[WIDTH];

  // Registered control, working register and results
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      work    <= '0;
      cnt     <= '0;
      op_q    <= '0;
      shout   <= 1'b0;
      dout_q  <= '0;
      carry_q <= 1'b0;
    end else if (bus.en) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            work  <= bus.din;
            op_q  <= bus.op;
            cnt   <= bus.amount;
            shout <= 1'b0;
            if (bus.amount == '0) begin
              // Nothing to shift: result is the operand, nothing shifted out.
              state   <= DONE;
              dout_q  <= bus.din;
              carry_q <= 1'b0;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work  <= step_val;
          shout <= step_out;
          cnt   <= cnt - AMT_W'(1);
          // Counter reaches zero on this edge: publish the result.
          if (cnt == AMT_W'(1)) begin
            state   <= DONE;
            dout_q  <= step_val;
            carry_q <= step_out;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode; illegal encodings decode as idle.
  assign bus.busy  = (state == SHIFT) || (state == DONE);
  assign bus.done  = (state == DONE);
  assign bus.dout  = dout_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  shift_sequencer_if #(.WIDTH(8), .AMT_W(3)) bus ();

  shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let the accepting edge pass.
  task automatic issue(input logic [7:0] d, input logic [2:0] a, input logic [1:0] o);
    bus.din    = d;
    bus.amount = a;
    bus.op     = o;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  // Count edges (including the accepting one) until done, bounded by limit.
  task automatic wait_done(input int limit, output int n, output int busy_n);
    n      = 1;
    busy_n = bus.busy ? 1 : 0;
    while (!bus.done && n < limit) begin
      tick();
      n++;
      busy_n += bus.busy ? 1 : 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b1; bus.start = 1'b0;
    bus.din = 8'h00; bus.amount = 3'd0; bus.op = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy actual=%b required=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done actual=%b required=0", bus.done); end
    checks++; if (bus.dout !== 8'h00) begin fails++; $display("FAIL reset_dout actual=%h required=00", bus.dout); end
    checks++; if (bus.carry !== 1'b0) begin fails++; $display("FAIL reset_carry actual=%b required=0", bus.carry); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle_busy actual=%b required=0", bus.busy); end
  endtask

  task automatic test_lsl();
    int n, b;
    issue(8'hB3, 3'd3, 2'b00);
    wait_done(20, n, b);
    checks++; if (n !== 4) begin fails++; $display("FAIL lsl_latency actual=%0d required=4", n); end
    checks++; if (bus.done !== 1'b1) begin fails++; $display("FAIL lsl_done actual=%b required=1", bus.done); end
    checks++; if (bus.dout !== 8'h98) begin fails++; $display("FAIL lsl_dout actual=%h required=98", bus.dout); end
    checks++; if (bus.carry !== 1'b1) begin fails++; $display("FAIL lsl_carry actual=%b required=1", bus.carry); end
    checks++; if (b !== 4) begin fails++; $display("FAIL lsl_busy_cycles actual=%0d required=4", b); end
    tick();
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin fails++; $display("FAIL lsl_after actual=%b required=00", {bus.busy, bus.done}); end
  endtask

  task automatic test_back_to_back();
    int n, b;
    issue(8'h96, 3'd2, 2'b10);
    wait_done(20, n, b);
    checks++; if (n !== 3) begin fails++; $display("FAIL asr_latency actual=%0d required=3", n); end
    checks++; if (bus.dout !== 8'hE5) begin fails++; $display("FAIL asr_dout actual=%h required=e5", bus.dout); end
    checks++; if (bus.carry !== 1'b1) begin fails++; $display("FAIL asr_carry actual=%b required=1", bus.carry); end
    tick();
    issue(8'h81, 3'd1, 2'b11);
    wait_done(20, n, b);
    checks++; if (n !== 2) begin fails++; $display("FAIL rol_latency actual=%0d required=2", n); end
    checks++; if (bus.dout !== 8'h03) begin fails++; $display("FAIL rol_dout actual=%h required=03", bus.dout); end
    checks++; if (bus.carry !== 1'b1) begin fails++; $display("FAIL rol_carry actual=%b required=1", bus.carry); end
    tick();
  endtask

  task automatic test_zero_amount();
    int n, b;
    issue(8'h01, 3'd0, 2'b01);
    wait_done(20, n, b);
    checks++; if (n !== 1) begin fails++; $display("FAIL zero_latency actual=%0d required=1", n); end
    checks++; if (bus.dout !== 8'h01) begin fails++; $display("FAIL zero_dout actual=%h required=01", bus.dout); end
    checks++; if (bus.carry !== 1'b0) begin fails++; $display("FAIL zero_carry actual=%b required=0", bus.carry); end
    tick();
    issue(8'h01, 3'd1, 2'b01);
    wait_done(20, n, b);
    checks++; if (n !== 2) begin fails++; $display("FAIL lsr_latency actual=%0d required=2", n); end
    checks++; if (bus.dout !== 8'h00) begin fails++; $display("FAIL lsr_dout actual=%h required=00", bus.dout); end
    checks++; if (bus.carry !== 1'b1) begin fails++; $display("FAIL lsr_carry actual=%b required=1", bus.carry); end
    tick();
  endtask

  task automatic test_stall();
    bus.en = 1'b1; bus.start = 1'b1;
    bus.din = 8'hFF; bus.amount = 3'd4; bus.op = 2'b00;
    tick();                                   // edge 1: accept
    bus.din = 8'h00; bus.amount = 3'd1; bus.op = 2'b01;
    tick();                                   // edge 2
    bus.en = 1'b0;
    tick();                                   // edge 3 stalled
    tick();                                   // edge 4 stalled
    bus.en = 1'b1;
    tick();                                   // edge 5
    tick();                                   // edge 6
    checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL stall_early_done actual=%b required=0", bus.done); end
    tick();                                   // edge 7
    checks++; if (bus.done !== 1'b1) begin fails++; $display("FAIL stall_done actual=%b required=1", bus.done); end
    checks++; if (bus.dout !== 8'hF0) begin fails++; $display("FAIL stall_dout actual=%h required=f0", bus.dout); end
    checks++; if (bus.carry !== 1'b1) begin fails++; $display("FAIL stall_carry actual=%b required=1", bus.carry); end
    bus.en = 1'b0;
    tick();
    checks++; if (bus.done !== 1'b1) begin fails++; $display("FAIL stall_hold_done actual=%b required=1", bus.done); end
    bus.en = 1'b1;
    tick();                                   // DONE -> IDLE, start still high
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin fails++; $display("FAIL stall_exit actual=%b required=00", {bus.busy, bus.done}); end
    bus.start = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL stall_single_op actual=%b required=0", bus.busy); end
  endtask

  task automatic test_abort();
    int n, b, seen;
    issue(8'h55, 3'd7, 2'b00);
    tick();
    tick();
    rst = 1'b1; bus.en = 1'b0;
    tick();
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin fails++; $display("FAIL abort_state actual=%b required=00", {bus.busy, bus.done}); end
    checks++; if (bus.dout !== 8'h00) begin fails++; $display("FAIL abort_dout actual=%h required=00", bus.dout); end
    checks++; if (bus.carry !== 1'b0) begin fails++; $display("FAIL abort_carry actual=%b required=0", bus.carry); end
    rst = 1'b0; bus.en = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen += bus.done ? 1 : 0;
    end
    checks++; if (seen !== 0) begin fails++; $display("FAIL abort_no_done actual=%0d required=0", seen); end
    issue(8'hC0, 3'd7, 2'b01);
    wait_done(30, n, b);
    checks++; if (n !== 8) begin fails++; $display("FAIL post_abort_latency actual=%0d required=8", n); end
    checks++; if (bus.dout !== 8'h01) begin fails++; $display("FAIL post_abort_dout actual=%h required=01", bus.dout); end
    checks++; if (bus.carry !== 1'b1) begin fails++; $display("FAIL post_abort_carry actual=%b required=1", bus.carry); end
    tick();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst = 1'b1;
    bus.en = 1'b0; bus.start = 1'b0;
    bus.din = '0; bus.amount = '0; bus.op = '0;
    test_reset();
    test_lsl();
    test_back_to_back();
    test_zero_amount();
    test_stall();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
